// File: rtl/sram_resp_ram.sv
// Synchronous word-organised RAM responder with byte-lane writes and a
// fully pipelined read path of READ_LATENCY cycles (1..4).
module sram_resp_ram #(
  parameter int ADDR_WIDTH   = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sram_en,
  input  logic [3:0]  sram_wen,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
  output logic [31:0] sram_rdata,
  output logic        rdata_valid
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $error("sram_resp_ram: READ_LATENCY must be in 1..4");
  end

  logic [ADDR_WIDTH-1:0] word_idx;
  logic [31:0]           mem_q [DEPTH];
  logic [31:0]           mem_rd;
  logic                  unused_addr;

  // Byte offset and bits above the array are don't-care; addresses alias.
  assign word_idx    = sram_addr[ADDR_WIDTH+1:2];
  assign unused_addr = ^{sram_addr[31:ADDR_WIDTH+2], sram_addr[1:0]};
  assign mem_rd      = mem_q[word_idx];

  // Array is not reset; writes are masked while reset is held low.
  always_ff @(posedge clk) begin
    if (resetn && sram_en) begin
      for (int i = 0; i < 4; i++) begin
        if (sram_wen[i]) mem_q[word_idx][8*i +: 8] <= sram_wdata[8*i +: 8];
      end
    end
  end

  if (READ_LATENCY == 1) begin : g_lat1
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        sram_rdata  <= 32'h0;
        rdata_valid <= 1'b0;
      end else begin
        rdata_valid <= sram_en;
        if (sram_en) sram_rdata <= mem_rd;
      end
    end
  end else begin : g_latn
    logic [READ_LATENCY-2:0] slot_v_q;
    logic [31:0]             slot_d_q [READ_LATENCY-1];

    // Output register is the last stage; it only loads on a valid slot so
    // sram_rdata holds the most recent response through idle cycles.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        slot_v_q    <= '0;
        for (int i = 0; i < READ_LATENCY-1; i++) slot_d_q[i] <= 32'h0;
        sram_rdata  <= 32'h0;
        rdata_valid <= 1'b0;
      end else begin
        slot_v_q[0] <= sram_en;
        slot_d_q[0] <= mem_rd;
        for (int i = 1; i < READ_LATENCY-1; i++) begin
          slot_v_q[i] <= slot_v_q[i-1];
          slot_d_q[i] <= slot_d_q[i-1];
        end
        rdata_valid <= slot_v_q[READ_LATENCY-2];
        if (slot_v_q[READ_LATENCY-2]) sram_rdata <= slot_d_q[READ_LATENCY-2];
      end
    end
  end

endmodule

// File: doc/sram_resp_ram.md
Name: sram_resp_ram

Overview:
- Responder end of the core's SRAM-style memory port (en / 4-bit byte wen / 32-bit addr / wdata / rdata).
- Synchronous word-organised RAM with byte-lane writes and a parameterised, fully pipelined read latency.
- Serves as the inst-side or data-side memory behind the CPU top in simulation and FPGA builds.
- Emits rdata_valid so latency-tolerant initiators and the verification bench can check response timing.

Parameters:
- ADDR_WIDTH, 16, word-address bits; depth = 2^ADDR_WIDTH 32-bit words.
- READ_LATENCY, 1, cycles from request edge to rdata valid; legal range 1..4; other values are an elaboration error.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- resetn, input, 1, asynchronous active-low reset.
- sram_en, input, 1, request strobe; when 1 a read is launched this cycle.
- sram_wen, input, 4, byte write enables; bit i writes byte lane i (wdata[8i+7:8i]).
- sram_addr, input, 32, byte address; the word index is sram_addr[ADDR_WIDTH+1:2].
- sram_wdata, input, 32, write data.
- sram_rdata, output, 32, read data, registered.
- rdata_valid, output, 1, high for exactly the cycle in which sram_rdata carries a response.

Behaviour:
- Address mapping:
  - sram_addr[1:0] is ignored.
  - Bits above ADDR_WIDTH+1 are ignored, so addresses alias modulo the depth. No error is signalled.
- Write:
  - Occurs at a rising edge when sram_en=1 and sram_wen!=0.
  - Only enabled lanes are updated; other bytes keep their contents.
  - When sram_en=0, sram_wen is ignored.
- Read:
  - Launched at every rising edge with sram_en=1, including write cycles.
  - The array is read-first: a read and write to the same word in the same cycle returns the pre-write data.
  - A read in the cycle after a write returns the new data.
- Pipeline:
  - A request sampled at edge N drives sram_rdata and rdata_valid=1 after edge N+READ_LATENCY-1.
  - READ_LATENCY=1 therefore matches a classic synchronous SRAM: data appears in the cycle after the request.
  - Back-to-back requests are accepted every cycle with no bubbles, and responses return in order.
  - Implemented as a READ_LATENCY-deep shift of {valid, data}.
- Idle:
  - A pipeline slot carrying valid=0 drives rdata_valid=0.
  - sram_rdata holds its last valid value; it is not zeroed.
- Reset (resetn=0, asynchronous):
  - sram_rdata=32'h0, rdata_valid=0, all pipeline slots cleared to valid=0/data=0.
  - Array contents are not reset; they are undefined at power-up.
  - Reads in flight when reset asserts are discarded and produce no valid response after deassertion.
  - Writes in the edge where reset is low are suppressed.
- Deassertion: the first request may be presented in the first cycle with resetn=1.
- No backpressure exists: the initiator cannot stall the responder, and responses are never dropped.

Test Plan:
1. Reset → sram_rdata=0, rdata_valid=0. Write word 0x0000_0010 with 0xDEADBEEF (wen=4'hF). Read 0x10 → 0xDEADBEEF with rdata_valid=1 exactly one cycle after the read edge (READ_LATENCY=1).
2. Byte lanes: preload 0x11223344 at 0x20, then write wen=4'b0101 with wdata 0xAABBCCDD. Read → 0x11BB33DD.
3. Same-cycle read/write: word 0x30=0x1 (write 0x2 with en=1) → rdata=0x1 next cycle. Following read → 0x2.
4. READ_LATENCY=3, reads to 0x0/0x4/0x8 holding 0xA/0xB/0xC on consecutive cycles → responses 0xA, 0xB, 0xC on cycles N+3..N+5 with rdata_valid=1 continuously. After en=0, rdata_valid=0 and rdata stays 0xC.
5. Aliasing, ADDR_WIDTH=4: write 0x5A at 0x0000_0004, read 0x0000_0044 → 0x5A. Address bits [1:0]=2'b11 have no effect.
6. Reset mid-flight (READ_LATENCY=2): issue a read, assert resetn=0 between edges → outputs clear immediately. After release, no rdata_valid pulse. Array data written before reset is still readable.
